pong_bram_arbiter: RTL and testbench
====================================

Name: pong_bram_arbiter

Overview:
- Shares the single game-state BRAM port B among NUM_REQ requesters:
  - req 0: VGA readout FSM.
  - req 1: game-physics writer.
  - req 2: debug/UART.
- Uses a per-requester valid/ready command handshake.
- Round-robin grant, one command per cycle.
- Read data returns on a shared bus, with a per-requester one-cycle response strobe after a fixed latency.

Parameters:
- NUM_REQ, 3: number of requesters, 2..4.
- ADDR_W, 16: BRAM address width.
- DATA_W, 16: BRAM data width.
- RD_LATENCY, 2: clock edges from bram_addr change to q_b valid.

Ports:
- clk  in  1  system clock, 50 MHz; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  NUM_REQ  command pending, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  grant, combinational, one-hot or zero.
- rsp_valid  out  NUM_REQ  one-cycle read-data strobe per requester.
- rsp_rdata  out  DATA_W  registered read data, shared by all requesters.
- bram_addr  out  ADDR_W  registered address to BRAM port B.
- bram_wdata  out  DATA_W  registered write data.
- bram_we  out  1  registered write enable.
- q_b  in  DATA_W  BRAM port B read data.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - bram_addr, bram_wdata, rsp_rdata = 0; bram_we = 0; rsp_valid = 0.
  - RR pointer = NUM_REQ-1, so req 0 wins first.
  - Response tag pipeline cleared; in-flight reads are dropped with no rsp_valid.
- Handshake:
  - Requester i holds valid, we, addr and wdata stable until it samples req_ready[i] = 1 at a rising edge. That edge is the transfer.
  - req_ready[i] never asserts without req_valid[i].
  - req_ready is all-zero while reset == 0.
- Arbitration:
  - Search starts at pointer+1 modulo NUM_REQ; the first valid requester is granted.
  - The pointer updates to the granted index only on a grant.
  - No valid requesters: no grant, pointer holds.
- Command issue, at transfer edge k:
  - bram_addr <= req_addr[i]; bram_wdata <= req_wdata[i]; bram_we <= req_we[i].
  - Cycles with no transfer: bram_we <= 0; bram_addr and bram_wdata hold their last values.
- Read path:
  - A tag {valid, index} enters a shift pipeline of depth RD_LATENCY+1 at edge k; writes enter an invalid tag.
  - q_b is valid after edge k+RD_LATENCY.
  - After edge k+RD_LATENCY+1: rsp_rdata = q_b as sampled, and rsp_valid[i] = 1 for exactly one cycle.
  - Default latency: transfer edge to response = 3 edges.
  - rsp_rdata holds its value when no response is due.
- Throughput: back-to-back transfers every cycle; up to RD_LATENCY+1 reads in flight; responses return in issue order.
- Writes: no response. A read issued the cycle after a write to the same address returns the new data, because the BRAM port is write-first.
- Simultaneous events:
  - A requester may hold valid continuously; it is re-granted only after the others are served.
  - A single requester alone is granted every cycle.
- Reset mid-operation: all outputs return to reset values at that edge, and no stale rsp_valid appears after reset is released.

Optional Feature:
- Macro: ARB_FIXED_PRIO0_EN.
- Defined: requester 0 (VGA readout) wins whenever req_valid[0] = 1. The other requesters are round-robin among themselves, and the pointer ignores grants to requester 0.
- Undefined: pure round-robin across all NUM_REQ requesters, as described above.

Decomposition:
- Package pong_mem_pkg holds:
  - game-state register map constants: PADDLE1_Y_ADDR 16'h8002, PADDLE2_Y_ADDR 16'h8004, BALL_X_ADDR 16'h8008, BALL_Y_ADDR 16'h8009, P1_SCORE_ADDR 16'h800D, P2_SCORE_ADDR 16'h800E, GAME_STATE_ADDR 16'h800F.
  - requester index constants: REQ_VGA = 0, REQ_PHYS = 1, REQ_DBG = 2.
  - response tag typedef {valid, index}.
- Sub-module rr_grant: combinational round-robin grant from valid vector and pointer. It is instantiated once; the priority override wraps it.

Test Plan:
- Reset release with req 0 reading 16'h8008, q_b model returning 16'h0140 → req_ready[0] on the first cycle; rsp_valid[0] 3 edges later with rsp_rdata = 16'h0140.
- All three requesters valid continuously → grants ordered 0,1,2,0,1,2; bram_addr follows each; no cycle without a grant.
- Req 1 writes 16'h8002 = 16'h00F0, req 0 reads 16'h8002 in the next cycle → rsp_rdata = 16'h00F0 to requester 0 only; no rsp_valid[1].
- Four back-to-back reads from req 0 (16'h800D, 16'h800E, 16'h800F, 16'h8009) → four consecutive rsp_valid[0] pulses, data in issue order.
- Reset asserted one cycle after a read transfer → no rsp_valid for that read; bram_we = 0 and bram_addr = 0 after the edge.
- With ARB_FIXED_PRIO0_EN, req 0 and req 2 valid for 5 cycles → req 0 granted all 5 cycles, req 2 granted on the first cycle after req 0 drops.

Source files
------------

// File: rtl/pong_mem_pkg.sv
// Shared definitions for the Pong game-state memory: register map,
// requester indices and the read-response tag carried through the
// arbiter's latency pipeline.
package pong_mem_pkg;

   // Game-state register map in the BRAM address space
   localparam logic [15:0] PADDLE1_Y_ADDR  = 16'h8002;
   localparam logic [15:0] PADDLE2_Y_ADDR  = 16'h8004;
   localparam logic [15:0] BALL_X_ADDR     = 16'h8008;
   localparam logic [15:0] BALL_Y_ADDR     = 16'h8009;
   localparam logic [15:0] P1_SCORE_ADDR   = 16'h800D;
   localparam logic [15:0] P2_SCORE_ADDR   = 16'h800E;
   localparam logic [15:0] GAME_STATE_ADDR = 16'h800F;

   // Requester indices on the arbiter
   localparam int REQ_VGA  = 0;
   localparam int REQ_PHYS = 1;
   localparam int REQ_DBG  = 2;

   // Index width covers up to four requesters
   localparam int IDX_W = 2;

   // Response tag: a read in flight and who gets its data
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] index;
   } rsp_tag_t;

endpackage

// File: rtl/pong_bram_arbiter_rr_grant.sv
// rr_grant: combinational round-robin pick. The search starts one past
// the pointer (modulo NUM_REQ) and grants the first valid requester.
module rr_grant
   import pong_mem_pkg::*;
#(
   parameter int NUM_REQ = 3
)
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   // Walk the requesters in rotating order starting after the pointer
   always_comb begin
      int cand;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(ptr) + off) % NUM_REQ;
         if (!grant_any && valid[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
            grant_any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pong_bram_arbiter.sv
// pong_bram_arbiter: shares BRAM port B among NUM_REQ requesters with a
// valid/ready handshake, round-robin grant and one command per cycle.
// Read data returns on a shared bus with a per-requester strobe
// RD_LATENCY+1 edges after the transfer edge.
// Build option: define ARB_FIXED_PRIO0_EN to give requester 0 (VGA)
// absolute priority; the others then rotate among themselves.
module pong_bram_arbiter
   import pong_mem_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 2
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [ADDR_W-1:0]         bram_addr,
   output logic [DATA_W-1:0]         bram_wdata,
   output logic                      bram_we,
   input  logic [DATA_W-1:0]         q_b
);

   localparam int TAG_DEPTH = RD_LATENCY + 1;

   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] rr_valid;
   logic [NUM_REQ-1:0] rr_grant_vec;
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_any;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_any;
   logic               ptr_upd;

   logic [ADDR_W-1:0]  cmd_addr;
   logic [DATA_W-1:0]  cmd_wdata;
   logic               cmd_we;

   logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
   logic [DATA_W-1:0]  bram_wdata_q, bram_wdata_d;
   logic               bram_we_q, bram_we_d;
   logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   rsp_tag_t           tag_q [TAG_DEPTH];
   rsp_tag_t           tag_d [TAG_DEPTH];

   rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
      .valid     (rr_valid),
      .ptr       (ptr_q),
      .grant     (rr_grant_vec),
      .grant_idx (rr_idx),
      .grant_any (rr_any)
   );

`ifdef ARB_FIXED_PRIO0_EN
   // Requester 0 overrides the rotation; the pointer only tracks the others
   always_comb begin
      rr_valid    = req_valid;
      rr_valid[0] = 1'b0;
      grant       = rr_grant_vec;
      grant_idx   = rr_idx;
      grant_any   = rr_any;
      ptr_upd     = rr_any;
      if (req_valid[0]) begin
         grant     = '0;
         grant[0]  = 1'b1;
         grant_idx = '0;
         grant_any = 1'b1;
         ptr_upd   = 1'b0;
      end
   end
`else
   // Pure rotation across every requester
   always_comb begin
      rr_valid  = req_valid;
      grant     = rr_grant_vec;
      grant_idx = rr_idx;
      grant_any = rr_any;
      ptr_upd   = rr_any;
   end
`endif

   // Grant is withheld entirely while reset is held
   assign req_ready = reset ? grant : '0;

   // Select the granted requester's command fields
   always_comb begin
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_we    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            cmd_addr  = req_addr[i*ADDR_W +: ADDR_W];
            cmd_wdata = req_wdata[i*DATA_W +: DATA_W];
            cmd_we    = req_we[i];
         end
      end
   end

   // Next state: pointer, BRAM command, tag shift and response decode
   always_comb begin
      ptr_d        = ptr_upd ? grant_idx : ptr_q;
      bram_addr_d  = grant_any ? cmd_addr  : bram_addr_q;
      bram_wdata_d = grant_any ? cmd_wdata : bram_wdata_q;
      bram_we_d    = grant_any & cmd_we;

      tag_d[0] = rsp_tag_t'{valid: grant_any & ~cmd_we, index: grant_idx};
      for (int j = 1; j < TAG_DEPTH; j++) begin
         tag_d[j] = tag_q[j-1];
      end

      // Oldest tag lines up with q_b being valid for its read
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      if (tag_q[TAG_DEPTH-1].valid) begin
         rsp_rdata_d = q_b;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_q[TAG_DEPTH-1].index == IDX_W'(i)) begin
               rsp_valid_d[i] = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q        <= IDX_W'(NUM_REQ - 1);
         bram_addr_q  <= '0;
         bram_wdata_q <= '0;
         bram_we_q    <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_valid_q  <= '0;
         for (int j = 0; j < TAG_DEPTH; j++) begin
            tag_q[j] <= '0;
         end
      end else begin
         ptr_q        <= ptr_d;
         bram_addr_q  <= bram_addr_d;
         bram_wdata_q <= bram_wdata_d;
         bram_we_q    <= bram_we_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_valid_q  <= rsp_valid_d;
         for (int j = 0; j < TAG_DEPTH; j++) begin
            tag_q[j] <= tag_d[j];
         end
      end
   end

   assign bram_addr  = bram_addr_q;
   assign bram_wdata = bram_wdata_q;
   assign bram_we    = bram_we_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_valid  = rsp_valid_q;

endmodule

// File: tb/tb_pong_bram_arbiter.sv
// Testbench for pong_bram_arbiter: write-first BRAM model with two-cycle
// read, a transaction-level reference (last-granted index, shadow memory,
// response queue), an arbitration vector table, directed corner cases
// and a randomized phase.
module tb_pong_bram_arbiter;
   import pong_mem_pkg::*;

   localparam int NR = 3;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int RL = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req_valid, req_we, req_ready, rsp_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, bram_wdata, q_b;
   logic [AW-1:0]   bram_addr;
   logic            bram_we;

   always #10 clk = ~clk;

   pong_bram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata),
      .bram_we    (bram_we),
      .q_b        (q_b)
   );

   // ---------------- BRAM port B model (write-first, 2-cycle read) -------
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] q1;
   logic          pl_init, pl_en;
   logic [7:0]    pl_addr;
   logic [DW-1:0] pl_data;

   function automatic logic [DW-1:0] init_val(int i);
      return DW'(i * 37 + 16'h1000);
   endfunction

   always @(posedge clk) begin
      if (pl_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (bram_we === 1'b1) begin
         mem[bram_addr[7:0]] <= bram_wdata;
      end
      q1  <= (bram_we === 1'b1) ? bram_wdata : mem[bram_addr[7:0]];
      q_b <= q1;
   end

   // ---------------- reference model state ----------------
   typedef struct {
      int            due;
      int            idx;
      logic [DW-1:0] data;
   } rsp_t;

   int            checks = 0;
   int            errors = 0;
   int            last_g;
   int            cyc;
   logic [DW-1:0] shadow [0:255];
   rsp_t          rq [$];
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata, exp_rdata;
   logic [NR-1:0] obs_ready, exp_g_last;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // Which requester the rules say gets the port, or -1
   function automatic int pick(logic [NR-1:0] v);
`ifdef ARB_FIXED_PRIO0_EN
      if (v[0]) return 0;
      for (int k = 1; k <= NR; k++) begin
         int c;
         c = (last_g + k) % NR;
         if (c != 0 && v[c]) return c;
      end
`else
      for (int k = 1; k <= NR; k++) begin
         int c;
         c = (last_g + k) % NR;
         if (v[c]) return c;
      end
`endif
      return -1;
   endfunction

   // One clock: check grant before the edge, outputs after it
   task automatic step();
      int            g;
      logic [NR-1:0] eg, erv;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic          w;
      a = '0; wd = '0; w = 1'b0;
      @(negedge clk);
      g  = reset ? pick(req_valid) : -1;
      eg = '0;
      if (g >= 0) begin
         eg[g] = 1'b1;
         a  = req_addr[g*AW +: AW];
         wd = req_wdata[g*DW +: DW];
         w  = req_we[g];
      end
      obs_ready  = req_ready;
      exp_g_last = eg;
      chk("req_ready", 32'(req_ready), 32'(eg));
      @(posedge clk);
      #1;
      if (!reset) begin
         last_g = NR - 1;
         rq.delete();
         exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
         chk("rst_bram_we", 32'(bram_we), 32'd0);
         chk("rst_bram_addr", 32'(bram_addr), 32'd0);
         chk("rst_bram_wdata", 32'(bram_wdata), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
         $display("cyc=%0d reset", cyc);
      end else begin
         cyc++;
         if (g >= 0) begin
`ifdef ARB_FIXED_PRIO0_EN
            if (g != 0) last_g = g;
`else
            last_g = g;
`endif
            exp_addr  = a;
            exp_wdata = wd;
            if (w) shadow[a[7:0]] = wd;
            else rq.push_back('{due: cyc + RL + 1, idx: g, data: shadow[a[7:0]]});
         end
         chk("bram_we", 32'(bram_we), 32'(g >= 0 && w));
         chk("bram_addr", 32'(bram_addr), 32'(exp_addr));
         chk("bram_wdata", 32'(bram_wdata), 32'(exp_wdata));
         erv = '0;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            erv[rq[0].idx] = 1'b1;
            exp_rdata = rq[0].data;
            void'(rq.pop_front());
         end
         chk("rsp_valid", 32'(rsp_valid), 32'(erv));
         chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
         $display("cyc=%0d grant=%b we=%b addr=%h rsp=%b rdata=%h",
                  cyc, obs_ready, bram_we, bram_addr, rsp_valid, rsp_rdata);
      end
   endtask

   task automatic set_cmd(input int i, input logic v, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]           = v;
      req_we[i]              = w;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en   = 1'b1;
      pl_addr = a[7:0];
      pl_data = d;
      shadow[a[7:0]] = d;
      @(posedge clk);
      #1;
      pl_en = 1'b0;
   endtask

   // ---------------- arbitration vector table ----------------
   typedef struct {
      logic [NR-1:0] v;
      logic [NR-1:0] exp;
   } vec_t;
   vec_t tbl [12];

   logic [DW-1:0] cd [4];
   logic [AW-1:0] ca [4];

   initial begin
      reset = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      pl_init = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      last_g = NR - 1; cyc = 0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

`ifdef ARB_FIXED_PRIO0_EN
      tbl = '{'{3'b111,3'b001}, '{3'b111,3'b001}, '{3'b111,3'b001}, '{3'b111,3'b001},
              '{3'b000,3'b000}, '{3'b100,3'b100}, '{3'b100,3'b100}, '{3'b011,3'b001},
              '{3'b011,3'b001}, '{3'b101,3'b001}, '{3'b110,3'b010}, '{3'b110,3'b100}};
`else
      tbl = '{'{3'b111,3'b001}, '{3'b111,3'b010}, '{3'b111,3'b100}, '{3'b111,3'b001},
              '{3'b000,3'b000}, '{3'b100,3'b100}, '{3'b100,3'b100}, '{3'b011,3'b001},
              '{3'b011,3'b010}, '{3'b101,3'b100}, '{3'b101,3'b001}, '{3'b010,3'b010}};
`endif

      @(posedge clk); #1;
      pl_init = 1'b1;
      @(posedge clk); #1;
      pl_init = 1'b0;
      preload(BALL_X_ADDR,     16'h0140);
      preload(P1_SCORE_ADDR,   16'h0003);
      preload(P2_SCORE_ADDR,   16'h0005);
      preload(GAME_STATE_ADDR, 16'h0002);
      preload(BALL_Y_ADDR,     16'h00A0);

      // Reset state
      step();

      // Reset release: VGA reads BALL_X, response 3 edges after transfer
      reset = 1'b1;
      set_cmd(REQ_VGA, 1'b1, 1'b0, BALL_X_ADDR, '0);
      step();
      chk("A_first_grant", 32'(obs_ready), 32'b001);
      set_cmd(REQ_VGA, 1'b0, 1'b0, '0, '0);
      step(); chk("A_no_rsp_e1", 32'(rsp_valid), 32'd0);
      step(); chk("A_no_rsp_e2", 32'(rsp_valid), 32'd0);
      step(); chk("A_rsp_e3", 32'(rsp_valid), 32'b001);
      chk("A_rdata", 32'(rsp_rdata), 32'h0140);

      // Physics writes PADDLE1_Y, VGA reads it back the next cycle
      set_cmd(REQ_PHYS, 1'b1, 1'b1, PADDLE1_Y_ADDR, 16'h00F0);
      step(); chk("B_wr_grant", 32'(obs_ready), 32'b010);
      set_cmd(REQ_PHYS, 1'b0, 1'b0, '0, '0);
      set_cmd(REQ_VGA, 1'b1, 1'b0, PADDLE1_Y_ADDR, '0);
      step(); chk("B_rd_grant", 32'(obs_ready), 32'b001);
      chk("B_no_rsp1", 32'(rsp_valid[REQ_PHYS]), 32'd0);
      set_cmd(REQ_VGA, 1'b0, 1'b0, '0, '0);
      for (int j = 0; j < 3; j++) begin
         step();
         chk("B_no_rsp1", 32'(rsp_valid[REQ_PHYS]), 32'd0);
      end
      chk("B_rsp0", 32'(rsp_valid), 32'b001);
      chk("B_rdata", 32'(rsp_rdata), 32'h00F0);

      // Four back-to-back reads from VGA, responses in issue order
      ca = '{P1_SCORE_ADDR, P2_SCORE_ADDR, GAME_STATE_ADDR, BALL_Y_ADDR};
      cd = '{16'h0003, 16'h0005, 16'h0002, 16'h00A0};
      for (int j = 0; j < 8; j++) begin
         if (j < 4) set_cmd(REQ_VGA, 1'b1, 1'b0, ca[j], '0);
         else       set_cmd(REQ_VGA, 1'b0, 1'b0, '0, '0);
         step();
         if (j >= 3 && j <= 6) begin
            chk("C_rsp_valid", 32'(rsp_valid), 32'b001);
            chk("C_rdata", 32'(rsp_rdata), 32'(cd[j-3]));
         end else begin
            chk("C_rsp_idle", 32'(rsp_valid), 32'd0);
         end
      end

      // Arbitration table from a fresh reset
      reset = 1'b0; req_valid = '0;
      step();
      reset = 1'b1;
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < NR; i++)
            set_cmd(i, tbl[r].v[i], 1'b0, 16'h8000 + AW'(i * 16), '0);
         step();
         chk("tbl_ready", 32'(obs_ready), 32'(tbl[r].exp));
         for (int i = 0; i < NR; i++)
            if (tbl[r].exp[i]) chk("tbl_addr", 32'(bram_addr), 32'(16'h8000 + i * 16));
      end
      req_valid = '0;
      for (int j = 0; j < 4; j++) step();

      // Reset one cycle after a read transfer drops its response
      set_cmd(REQ_VGA, 1'b1, 1'b0, BALL_Y_ADDR, '0);
      step();
      set_cmd(REQ_VGA, 1'b0, 1'b0, '0, '0);
      reset = 1'b0;
      step();
      chk("D_bram_we", 32'(bram_we), 32'd0);
      chk("D_bram_addr", 32'(bram_addr), 32'd0);
      reset = 1'b1;
      for (int j = 0; j < 5; j++) begin
         step();
         chk("D_no_stale_rsp", 32'(rsp_valid), 32'd0);
      end

`ifdef ARB_FIXED_PRIO0_EN
      // VGA holds off the debug port while it stays valid
      set_cmd(REQ_VGA, 1'b1, 1'b0, BALL_X_ADDR, '0);
      set_cmd(REQ_DBG, 1'b1, 1'b0, GAME_STATE_ADDR, '0);
      for (int j = 0; j < 5; j++) begin
         step();
         chk("F_prio0", 32'(obs_ready), 32'b001);
      end
      set_cmd(REQ_VGA, 1'b0, 1'b0, '0, '0);
      step();
      chk("F_dbg_after", 32'(obs_ready), 32'b100);
      req_valid = '0;
      for (int j = 0; j < 4; j++) step();
`endif

      // Randomized traffic against the reference model
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] && $urandom_range(0, 99) < 55)
               set_cmd(i, 1'b1, ($urandom_range(0, 2) == 0),
                       16'h8000 + AW'($urandom_range(0, 15)), DW'($urandom));
         end
         step();
         for (int i = 0; i < NR; i++)
            if (exp_g_last[i]) req_valid[i] = 1'b0;
      end
      req_valid = '0;
      for (int j = 0; j < 5; j++) step();
      chk("drain_empty", 32'(rq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
